// File: rtl/wave_pkg.sv
// Shared types and helpers for the wave capture path: FSM states, frame geometry
// and the sample-to-screen scaling used when writing the sample RAM.
package wave_pkg;

  localparam int SAMPLES_PER_FRAME = 256;
  localparam int ADDR_W            = 9;
  localparam int DATA_W            = 8;
  localparam int IDX_W             = 8;

  typedef enum logic [1:0] {
    ST_ARMED  = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_WAIT   = 2'd2
  } wave_state_e;

  // Top byte of a signed sample -> row: most positive lands on row 0.
  function automatic logic [DATA_W-1:0] scale_sample(input logic [7:0] top_byte);
    return {top_byte[7], ~top_byte[6:0]};
  endfunction

endpackage

// File: rtl/wave_trigger.sv
// Positive zero-crossing detector feeding the capture FSM; with WAVE_CAPTURE_TIMEOUT_EN
// defined, a sample counter also forces a trigger after TIMEOUT samples spent armed.
module wave_trigger #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset_n,
  input  logic new_sample,
  input  logic sample_msb,
  input  logic armed,
  output logic trigger
);

  logic prev_msb_q;
  logic prev_msb_d;
  logic crossing;

  // Sign history is tracked in every state so the first sample after a swap sees it.
  assign prev_msb_d = new_sample ? sample_msb : prev_msb_q;
  assign crossing   = prev_msb_q & ~sample_msb;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev_msb_q <= 1'b0;
    end else begin
      prev_msb_q <= prev_msb_d;
    end
  end

`ifdef WAVE_CAPTURE_TIMEOUT_EN
  logic [10:0] count_q;
  logic [10:0] count_d;
  logic        timeout;

  always_comb begin
    count_d = count_q;
    if (!armed) begin
      count_d = '0;
    end else if (new_sample) begin
      count_d = count_q + 11'd1;
    end
  end

  assign timeout = (count_q == 11'(TIMEOUT - 1));
  assign trigger = armed & new_sample & (crossing | timeout);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign trigger        = armed & new_sample & crossing;
`endif

endmodule

// File: rtl/wave_capture.sv
// Double-buffered waveform capture: writes one 256-sample frame into the hidden RAM half,
// then swaps halves on frame_start. Optional forced trigger via WAVE_CAPTURE_TIMEOUT_EN.
module wave_capture
  import wave_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              new_sample,
  input  logic [15:0]       sample,
  input  logic              frame_start,
  output logic              write_en,
  output logic [ADDR_W-1:0] write_address,
  output logic [DATA_W-1:0] write_sample,
  output logic              read_index,
  output logic              busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SAMPLES_PER_FRAME - 1);

  wave_state_e       state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              read_index_q, read_index_d;
  logic              write_en_q, write_en_d;
  logic [ADDR_W-1:0] write_address_q, write_address_d;
  logic [DATA_W-1:0] write_sample_q, write_sample_d;
  logic              trigger;
  logic              unused_sample_lsb;

  assign unused_sample_lsb = ^sample[7:0];

  wave_trigger #(
    .TIMEOUT (TIMEOUT)
  ) u_trigger (
    .clk        (clk),
    .reset_n    (reset_n),
    .new_sample (new_sample),
    .sample_msb (sample[15]),
    .armed      (state_q == ST_ARMED),
    .trigger    (trigger)
  );

  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    read_index_d    = read_index_q;
    write_en_d      = 1'b0;
    write_address_d = write_address_q;
    write_sample_d  = write_sample_q;
    unique case (state_q)
      ST_ARMED: begin
        if (trigger) begin
          write_en_d      = 1'b1;
          write_address_d = {~read_index_q, {IDX_W{1'b0}}};
          write_sample_d  = scale_sample(sample[15:8]);
          idx_d           = IDX_W'(1);
          state_d         = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (new_sample) begin
          write_en_d      = 1'b1;
          write_address_d = {~read_index_q, idx_q};
          write_sample_d  = scale_sample(sample[15:8]);
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = ST_WAIT;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_WAIT: begin
        // The only place the halves swap, so a frame being written is never shown.
        if (frame_start) begin
          read_index_d = ~read_index_q;
          state_d      = ST_ARMED;
        end
      end
      default: state_d = ST_ARMED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q         <= ST_ARMED;
      idx_q           <= '0;
      read_index_q    <= 1'b0;
      write_en_q      <= 1'b0;
      write_address_q <= {1'b1, {IDX_W{1'b0}}};
      write_sample_q  <= '0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      read_index_q    <= read_index_d;
      write_en_q      <= write_en_d;
      write_address_q <= write_address_d;
      write_sample_q  <= write_sample_d;
    end
  end

  assign write_en      = write_en_q;
  assign write_address = write_address_q;
  assign write_sample  = write_sample_q;
  assign read_index    = read_index_q;
  assign busy          = (state_q == ST_ACTIVE) || (state_q == ST_WAIT);

endmodule
